// File: rtl/sega_pad_scanner_pkg.sv
// Shared constants and types for the DB9 pad scanner: the phase schedule,
// the bit positions inside the MXYZ SACB RLDU word, and the pad pin layout.
package sega_pad_pkg;

  typedef logic [11:0] pad_word_t;
  typedef logic [7:0]  phase_t;

  // Synchronised pin bundle, same bit order as the joyN_pins_i ports.
  typedef struct packed {
    logic p9;
    logic p6;
    logic right;
    logic left;
    logic down;
    logic up;
  } pad_pins_t;

  localparam phase_t PH_SEL_LO0    = 8'd0;
  localparam phase_t PH_SAMPLE_DIR = 8'd2;
  localparam phase_t PH_SAMPLE_SA  = 8'd3;
  localparam phase_t PH_DETECT6    = 8'd5;
  localparam phase_t PH_SAMPLE_XYZ = 8'd6;
  localparam phase_t PH_PUBLISH    = 8'd7;

  localparam int BIT_U = 0;
  localparam int BIT_D = 1;
  localparam int BIT_L = 2;
  localparam int BIT_R = 3;
  localparam int BIT_B = 4;
  localparam int BIT_C = 5;
  localparam int BIT_A = 6;
  localparam int BIT_S = 7;
  localparam int BIT_Z = 8;
  localparam int BIT_Y = 9;
  localparam int BIT_X = 10;
  localparam int BIT_M = 11;

  localparam pad_word_t WORD_IDLE = 12'hFFF;

  // Select level driven after the tick of a given phase: it alternates low/high
  // from PH_SEL_LO0 through PH_PUBLISH and then rests high for the rest of the scan.
  function automatic logic select_level(input phase_t phase);
    return (phase > PH_PUBLISH) ? 1'b1 : phase[0];
  endfunction

endpackage

// File: rtl/sega_pad_scanner_if.sv
// Pad-side and consumer-side signals of the scanner. The master modport belongs
// to the scanner; the slave modport is the board/consumer view.
interface sega_pad_scanner_if;
  import sega_pad_pkg::*;

  logic [5:0] joy1_pins_i;
  logic [5:0] joy2_pins_i;
  logic       p7_o;
  pad_word_t  joy1_o;
  pad_word_t  joy2_o;
  logic       six1_o;
  logic       six2_o;
  logic       valid_o;

  modport master (
    input  joy1_pins_i,
    input  joy2_pins_i,
    output p7_o,
    output joy1_o,
    output joy2_o,
    output six1_o,
    output six2_o,
    output valid_o
  );

  modport slave (
    output joy1_pins_i,
    output joy2_pins_i,
    input  p7_o,
    input  joy1_o,
    input  joy2_o,
    input  six1_o,
    input  six2_o,
    input  valid_o
  );

endinterface

// File: rtl/sega_pad_scanner_port.sv
// One DB9 port: synchronises the pad pins, fills a shadow word across the
// select phases and publishes it as a whole on the publish phase.
module sega_pad_port
  import sega_pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick,
  input  phase_t     phase,
  input  logic [5:0] pins_async,
  output pad_word_t  word,
  output logic       six
);

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  pad_pins_t                   pins;
  logic [3:0]                  rldu;
  pad_word_t                   shadow;
  logic                        six_shadow;

  // NOTE: the synchroniser chain is reset to the idle (released) level so that
  // the first samples after reset look like an unplugged pad, never like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins_async};
    end
  end

  assign pins = sync_q[SYNC_STAGES-1];
  assign rldu = {pins.right, pins.left, pins.down, pins.up};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow     <= WORD_IDLE;
      six_shadow <= 1'b0;
      word       <= WORD_IDLE;
      six        <= 1'b0;
    end else if (tick) begin
      unique case (phase)
        PH_SAMPLE_DIR: begin
          shadow[BIT_R:BIT_U] <= rldu;
          shadow[BIT_C:BIT_B] <= {pins.p9, pins.p6};
          six_shadow          <= 1'b0;
        end
        PH_SAMPLE_SA: begin
          // Left+right both low is impossible on a d-pad: that is the Mega Drive ID.
          if (!pins.right && !pins.left) begin
            shadow[BIT_S:BIT_A] <= {pins.p9, pins.p6};
          end else begin
            shadow[BIT_S:BIT_B] <= {2'b11, pins.p9, pins.p6};
          end
        end
        PH_DETECT6: begin
          if (rldu == 4'b0000) begin
            six_shadow <= 1'b1;
          end
        end
        PH_SAMPLE_XYZ: begin
          if (six_shadow) begin
            shadow[BIT_M:BIT_Z] <= rldu;
          end
        end
        PH_PUBLISH: begin
          word[BIT_S:BIT_U] <= shadow[BIT_S:BIT_U];
          word[BIT_M:BIT_Z] <= six_shadow ? shadow[BIT_M:BIT_Z] : 4'hF;
          six               <= six_shadow;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sega_pad_scanner.sv
// Top of the DB9 pad scanner: phase tick generator, shared select line and
// the two per-port scanners; results publish once per 256-phase scan.
module sega_pad_scanner
  import sega_pad_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1536,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sega_pad_scanner_if.master  bus
);

  localparam logic [15:0] TICK_RELOAD = 16'(TICK_DIV - 1);

  logic [15:0] tick_cnt;
  logic        tick;
  phase_t      phase;
  logic        p7_q;
  logic        p7_next;
  logic        valid_q;

  assign tick = (tick_cnt == 16'd0);

  // NOTE: every default is assigned before any condition so that no path
  // through this block leaves p7_next unassigned and infers a latch.
  always_comb begin
    p7_next = p7_q;
    if (tick) begin
      p7_next = select_level(phase);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // here samples the pre-edge values of tick/phase regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt <= TICK_RELOAD;
      phase    <= PH_SEL_LO0;
      p7_q     <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      tick_cnt <= tick ? TICK_RELOAD : tick_cnt - 16'd1;
      if (tick) begin
        phase <= phase + 8'd1;
      end
      p7_q    <= p7_next;
      valid_q <= tick && (phase == PH_PUBLISH);
    end
  end

  assign bus.p7_o    = p7_q;
  assign bus.valid_o = valid_q;

  sega_pad_port #(.SYNC_STAGES(SYNC_STAGES)) u_port1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tick       (tick),
    .phase      (phase),
    .pins_async (bus.joy1_pins_i),
    .word       (bus.joy1_o),
    .six        (bus.six1_o)
  );

  sega_pad_port #(.SYNC_STAGES(SYNC_STAGES)) u_port2 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tick       (tick),
    .phase      (phase),
    .pins_async (bus.joy2_pins_i),
    .word       (bus.joy2_o),
    .six        (bus.six2_o)
  );

endmodule
